// File: rtl/imem_fetch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : imem_fetch_ctrl
// Purpose  : Boot loader and IF-stage sequencer for a single-port,
//            synchronous-read instruction memory.
// Options  : FETCH_COUNT_EN - enables the delivered-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl #(
   parameter int          DEPTH    = 64,
   parameter int          AW       = 6,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_start,
   input  logic          run_start,
   input  logic          ld_valid,
   output logic          ld_ready,
   input  logic [31:0]   ld_data,
   input  logic          ld_last,
   output logic          ld_overflow,
   input  logic          halt_req,
   input  logic          stall,
   input  logic          br_taken,
   input  logic [31:0]   br_target,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata,
   output logic          if_valid,
   output logic [31:0]   if_instr,
   output logic [31:0]   if_pc,
   output logic [1:0]    state_o,
   output logic [31:0]   fetch_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_HALT = 2'd3
   } state_t;

   localparam logic [31:0] c_DEPTH     = 32'(DEPTH);
   localparam logic [AW:0] c_DEPTH_PTR = (AW+1)'(DEPTH);

   state_t      r_state;
   logic [31:0] r_pc;
   logic [AW:0] r_ptr;
   logic        r_ovf;
   logic        r_if_valid;
   logic [31:0] r_if_pc;
   logic [31:0] r_hold;
   logic        r_fresh;
   logic        r_oor;

   logic        w_load;
   logic        w_run;
   logic        w_accept;
   logic        w_room;
   logic        w_wr;
   logic        w_issue;
   logic [31:0] w_fetch_pc;
   logic        w_in_range;
   logic        w_rd;
   logic [31:0] w_cur_instr;
   logic        w_unused;

   assign w_load      = (r_state == S_LOAD);
   assign w_run       = (r_state == S_RUN);
   assign w_accept    = w_load && ld_valid;
   assign w_room      = (r_ptr < c_DEPTH_PTR);
   assign w_wr        = w_accept && w_room;
   assign w_issue     = w_run && !halt_req && (br_taken || !stall);
   assign w_fetch_pc  = br_taken ? {br_target[31:2], 2'b00} : r_pc;
   assign w_in_range  = ({2'b00, w_fetch_pc[31:2]} < c_DEPTH);
   assign w_rd        = w_issue && w_in_range;
   // Fresh data comes straight from memory; after the first stall cycle the
   // captured copy is shown so memory activity cannot disturb the output.
   assign w_cur_instr = r_fresh ? (r_oor ? 32'h0 : mem_rdata) : r_hold;
   assign w_unused    = ^br_target[1:0];

   assign mem_en      = w_wr || w_rd;
   assign mem_we      = w_wr;
   assign mem_addr    = w_load ? r_ptr[AW-1:0] : w_fetch_pc[AW+1:2];
   assign mem_wdata   = w_load ? ld_data : 32'h0;
   assign ld_ready    = w_load;
   assign ld_overflow = r_ovf;
   assign if_valid    = r_if_valid;
   assign if_pc       = r_if_pc;
   assign if_instr    = w_cur_instr;
   assign state_o     = r_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_PC;
         r_ptr      <= '0;
         r_ovf      <= 1'b0;
         r_if_valid <= 1'b0;
         r_if_pc    <= 32'h0;
         r_hold     <= 32'h0;
         r_fresh    <= 1'b0;
         r_oor      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (load_start) begin
                  r_state <= S_LOAD;
               end else if (run_start) begin
                  r_state <= S_RUN;
                  r_pc    <= RESET_PC;
               end
            end
            S_LOAD: begin
               if (w_accept) begin
                  if (w_room) r_ptr <= r_ptr + 1'b1;
                  else        r_ovf <= 1'b1;
                  if (ld_last) begin
                     r_state <= S_RUN;
                     r_pc    <= RESET_PC;
                     r_ptr   <= '0;
                  end
               end
            end
            S_RUN: begin
               if (halt_req) begin
                  r_state    <= S_HALT;
                  r_if_valid <= 1'b0;
               end else if (w_issue) begin
                  r_if_valid <= 1'b1;
                  r_if_pc    <= w_fetch_pc;
                  r_oor      <= !w_in_range;
                  r_fresh    <= 1'b1;
                  r_pc       <= w_fetch_pc + 32'd4;
               end else if (r_fresh) begin
                  r_hold  <= w_cur_instr;
                  r_fresh <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef FETCH_COUNT_EN
   logic [31:0] r_fetch_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                        r_fetch_count <= 32'h0;
      else if (r_if_valid && !stall)  r_fetch_count <= r_fetch_count + 32'd1;
   end

   assign fetch_count = r_fetch_count;
`else
   assign fetch_count = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch_ctrl
// Purpose  : Randomized self-checking bench with a behavioural fetch model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_ctrl;

   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic          clk = 1'b0;
   logic          rst, load_start, run_start, ld_valid, ld_last;
   logic          halt_req, stall, br_taken;
   logic [31:0]   ld_data, br_target;
   logic          ld_ready, ld_overflow, mem_en, mem_we, if_valid;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata, mem_rdata, if_instr, if_pc, fetch_count;
   logic [1:0]    state_o;

   int n_checks = 0;
   int n_err    = 0;

   // preload side channel into the bench memory (DUT idle while used)
   logic          pl_en = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [31:0]   pl_data = '0;

   int            wr_cnt;
   logic [31:0]   ram [DEPTH];

   always #5 clk = ~clk;

   imem_fetch_ctrl #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .load_start(load_start), .run_start(run_start),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
      .ld_last(ld_last), .ld_overflow(ld_overflow), .halt_req(halt_req),
      .stall(stall), .br_taken(br_taken), .br_target(br_target),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .if_valid(if_valid),
      .if_instr(if_instr), .if_pc(if_pc), .state_o(state_o),
      .fetch_count(fetch_count)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // Synchronous-read memory; returns junk whenever no read was strobed.
   initial begin
      wr_cnt = 0;
      mem_rdata = 32'h0;
      for (int i = 0; i < DEPTH; i++) ram[i] = 32'hA500_0000 + i;
      forever begin
         @(posedge clk);
         if (pl_en) ram[pl_addr] <= pl_data;
         if (mem_en && mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
         end
         if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
         else                   mem_rdata <= $urandom;
      end
   end

   // Behavioural model: program image plus the architectural IF-stage view.
   logic [31:0] img [DEPTH];
   int          m_state;
   logic [31:0] m_pc, m_ipc, m_instr, m_cnt;
   int          m_ptr;
   logic        m_ovf, m_valid;

   initial begin
      logic        e_en, e_we;
      logic [31:0] e_addr, a;
      for (int i = 0; i < DEPTH; i++) img[i] = 32'hA500_0000 + i;
      m_state = 0; m_pc = 0; m_ptr = 0; m_ovf = 0; m_valid = 0;
      m_ipc = 0; m_instr = 0; m_cnt = 0;
      forever begin
         @(negedge clk);
         if (pl_en) img[pl_addr] = pl_data;
         if (rst) begin
            chk("rst_state", {30'h0, state_o}, 32'd0);
            chk("rst_if_valid", {31'h0, if_valid}, 32'd0);
            chk("rst_if_instr", if_instr, 32'h0);
            chk("rst_if_pc", if_pc, 32'h0);
            chk("rst_mem_en", {31'h0, mem_en}, 32'd0);
            chk("rst_mem_we", {31'h0, mem_we}, 32'd0);
            chk("rst_ovf", {31'h0, ld_overflow}, 32'd0);
            chk("rst_count", fetch_count, 32'h0);
            m_state = 0; m_pc = 0; m_ptr = 0; m_ovf = 0; m_valid = 0; m_cnt = 0;
         end else begin
            e_en = 0; e_we = 0; e_addr = 0; a = 0;
            if (m_state == 1 && ld_valid && m_ptr < DEPTH) begin
               e_en = 1; e_we = 1; e_addr = m_ptr;
            end else if (m_state == 2 && !halt_req && (br_taken || !stall)) begin
               a = br_taken ? (br_target & ~32'd3) : m_pc;
               e_en = ((a >> 2) < DEPTH);
               e_addr = a >> 2;
            end
            chk("state", {30'h0, state_o}, m_state);
            chk("ld_ready", {31'h0, ld_ready}, {31'h0, m_state == 1});
            chk("mem_en", {31'h0, mem_en}, {31'h0, e_en});
            chk("mem_we", {31'h0, mem_we}, {31'h0, e_we});
            if (e_en) chk("mem_addr", {26'h0, mem_addr}, e_addr);
            if (e_we) chk("mem_wdata", mem_wdata, ld_data);
            chk("ld_overflow", {31'h0, ld_overflow}, {31'h0, m_ovf});
            chk("if_valid", {31'h0, if_valid}, {31'h0, m_valid});
            if (m_valid) begin
               chk("if_pc", if_pc, m_ipc);
               chk("if_instr", if_instr, m_instr);
            end
`ifdef FETCH_COUNT_EN
            chk("fetch_count", fetch_count, m_cnt);
            if (m_valid && !stall) m_cnt = m_cnt + 1;
`else
            chk("fetch_count", fetch_count, 32'h0);
`endif
            case (m_state)
               0: if (load_start) m_state = 1;
                  else if (run_start) begin m_state = 2; m_pc = 0; end
               1: if (ld_valid) begin
                     if (m_ptr < DEPTH) begin img[m_ptr] = ld_data; m_ptr++; end
                     else m_ovf = 1;
                     if (ld_last) begin m_state = 2; m_pc = 0; m_ptr = 0; end
                  end
               2: if (halt_req) begin m_state = 3; m_valid = 0; end
                  else if (br_taken || !stall) begin
                     m_valid = 1; m_ipc = a;
                     m_instr = ((a >> 2) < DEPTH) ? img[a >> 2] : 32'h0;
                     m_pc = a + 32'd4;
                  end
               default: ;
            endcase
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic rand_run(input int n);
      for (int i = 0; i < n; i++) begin
         stall     = ($urandom_range(0, 9) < 3);
         br_taken  = ($urandom_range(0, 9) == 0);
         br_target = $urandom_range(0, 4*DEPTH + 40);
         tick();
      end
      stall = 0; br_taken = 0;
   endtask

   initial begin
      int w0, cnt;
      logic [31:0] d [3];
      rst = 1; load_start = 0; run_start = 0; ld_valid = 0; ld_last = 0;
      ld_data = 0; halt_req = 0; stall = 0; br_taken = 0; br_target = 0;
      repeat (2) tick();
      rst = 0; tick();

      // reset in the middle of a load
      load_start = 1; tick(); load_start = 0;
      for (int i = 0; i < 3; i++) begin ld_valid = 1; ld_data = $urandom; tick(); end
      ld_valid = 0; rst = 1;
      @(negedge clk);
      chk("midload_rst_state", {30'h0, state_o}, 32'd0);
      tick(); rst = 0; tick();

      // 3-word boot load then run
      w0 = wr_cnt;
      for (int i = 0; i < 3; i++) d[i] = $urandom;
      load_start = 1; tick(); load_start = 0;
      for (int i = 0; i < 3; i++) begin
         ld_valid = 1; ld_data = d[i]; ld_last = (i == 2); tick();
      end
      ld_valid = 0; ld_last = 0;
      @(negedge clk);
      chk("load_writes", wr_cnt - w0, 32'd3);
      chk("load_first_addr", {26'h0, mem_addr}, 32'd0);
      tick(); @(negedge clk);
      chk("load_pc0_instr", if_instr, d[0]);
      tick(); @(negedge clk);
      chk("load_pc4", if_pc, 32'd4);
      chk("load_pc4_instr", if_instr, d[1]);
      repeat (4) tick();

      // run_start over preloaded words, stall and branch
      rst = 1; tick(); rst = 0;
      pl_en = 1; pl_addr = 0; pl_data = 32'h2001000A; tick();
      pl_addr = 1; pl_data = 32'h201E0014; tick();
      pl_en = 0;
      run_start = 1; @(negedge clk);
      chk("run_idle", {30'h0, state_o}, 32'd0);
      tick(); run_start = 0; @(negedge clk);
      chk("run_first_en", {31'h0, mem_en}, 32'd1);
      chk("run_first_valid", {31'h0, if_valid}, 32'd0);
      tick(); @(negedge clk);
      chk("run_pc0", if_pc, 32'd0);
      chk("run_instr0", if_instr, 32'h2001000A);
      tick(); stall = 1; @(negedge clk);
      chk("stall_pc4", if_pc, 32'd4);
      repeat (2) tick();
      @(negedge clk);
      chk("stall_hold_pc", if_pc, 32'd4);
      chk("stall_hold_instr", if_instr, 32'h201E0014);
      chk("stall_no_en", {31'h0, mem_en}, 32'd0);
      tick(); stall = 0; @(negedge clk);
      chk("resume_addr", {26'h0, mem_addr}, 32'd2);
      tick(); @(negedge clk);
      chk("resume_pc8", if_pc, 32'd8);
      tick(); br_taken = 1; br_target = 32'h0000000E; stall = 1; @(negedge clk);
      chk("br_addr", {26'h0, mem_addr}, 32'd3);
      tick(); br_taken = 0; stall = 0; @(negedge clk);
      chk("br_pc", if_pc, 32'h0000000C);

      // fetch past the end of memory
      tick(); br_taken = 1; br_target = 4*DEPTH - 4; tick(); br_taken = 0;
      @(negedge clk);
      chk("oor_no_en", {31'h0, mem_en}, 32'd0);
      tick(); @(negedge clk);
      chk("oor_valid", {31'h0, if_valid}, 32'd1);
      chk("oor_pc", if_pc, 4*DEPTH);
      chk("oor_instr", if_instr, 32'h0);
      rand_run(300);

      // overflowing boot load with random gaps
      rst = 1; tick(); rst = 0;
      w0 = wr_cnt; cnt = 0;
      load_start = 1; tick(); load_start = 0;
      for (int i = 0; i < 600 && cnt < DEPTH + 1; i++) begin
         ld_valid = ($urandom_range(0, 3) != 0);
         ld_data  = $urandom;
         ld_last  = ld_valid && (cnt == DEPTH);
         tick();
         if (ld_valid) cnt++;
      end
      ld_valid = 0; ld_last = 0;
      @(negedge clk);
      chk("ovf_flag", {31'h0, ld_overflow}, 32'd1);
      chk("ovf_writes", wr_cnt - w0, DEPTH);
      rand_run(200);

      // halt beats branch
      halt_req = 1; br_taken = 1; br_target = 32'h8; @(negedge clk);
      chk("halt_no_en", {31'h0, mem_en}, 32'd0);
      tick(); halt_req = 0; br_taken = 0; @(negedge clk);
      chk("halt_state", {30'h0, state_o}, 32'd3);
      chk("halt_valid", {31'h0, if_valid}, 32'd0);
      rand_run(5);
      @(negedge clk);
      chk("halt_still_no_en", {31'h0, mem_en}, 32'd0);
      tick(); rst = 1; @(negedge clk);
      chk("halt_rst_idle", {30'h0, state_o}, 32'd0);
      tick(); rst = 0; repeat (2) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Sequencing controller for the single-port, synchronous-read instruction memory in the 5-stage pipeline.
- Owns the memory port.
- After reset, optionally boot-loads the program through a valid/ready word stream.
- Then runs the IF stage: PC generation, sequential fetch, stall hold, branch redirect.
- Out-of-range fetches return NOP (0x00000000) without touching memory.

Parameters:
DEPTH, 64, instruction memory depth in 32-bit words
AW, 6, memory word-address width, clog2(DEPTH)
RESET_PC, 32'h0000_0000, byte address of the first fetch after load or run_start

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
load_start  in  1  IDLE only: enter LOAD
run_start  in  1  IDLE only: enter RUN without loading; load_start wins if both are high
ld_valid  in  1  boot word valid
ld_ready  out  1  boot word accepted when ld_valid&&ld_ready
ld_data  in  32  boot word
ld_last  in  1  marks the final boot word
ld_overflow  out  1  sticky: a boot word arrived after DEPTH words were written
halt_req  in  1  RUN: go to HALT
stall  in  1  IF stall from hazard unit
br_taken  in  1  redirect request
br_target  in  32  redirect byte address; bits [1:0] ignored
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory word address
mem_wdata  out  32  memory write data
mem_rdata  in  32  read data, valid one cycle after a read strobe
if_valid  out  1  if_instr/if_pc hold a valid fetched instruction
if_instr  out  32  fetched instruction
if_pc  out  32  byte address of if_instr
state_o  out  2  IDLE=0, LOAD=1, RUN=2, HALT=3
fetch_count  out  32  instructions delivered (see Optional Feature)

Behaviour:
Reset, asynchronous, any state including mid-load or mid-fetch:
- state=IDLE, pc=RESET_PC, load pointer=0, ld_overflow=0.
- Hold register cleared; if_valid=0; if_instr=0; if_pc=0.
- mem_en=0, mem_we=0; fetch_count=0.
- Memory contents are not cleared.

IDLE:
- All strobes low.
- load_start -> LOAD.
- run_start -> RUN with pc=RESET_PC.

LOAD:
- ld_ready=1.
- Each accepted word while pointer<DEPTH: mem_en=1, mem_we=1, mem_addr=pointer, mem_wdata=ld_data, same cycle; then pointer+1.
- Accepted word with pointer==DEPTH: no write, ld_overflow<=1.
- Accepted word with ld_last=1 -> RUN next cycle, pc=RESET_PC, pointer=0.
- ld_valid=0: nothing happens, stay in LOAD.

RUN:
- mem_we=0; ld_ready=0.
- Normal cycle (no stall, no branch):
  - if pc[31:2]<DEPTH: mem_en=1, mem_addr=pc[AW+1:2].
  - else no memory access and the returned instruction is forced to 0.
  - pc<=pc+4 (32-bit wrap).
  - Next cycle: if_valid=1, if_pc=issued pc, if_instr=mem_rdata (or 0 if out of range).
  - Latency is 1 cycle.
- stall=1:
  - no read issued, pc holds.
  - if_valid/if_pc/if_instr hold their values for every stall cycle. On the first stall cycle, mem_rdata is captured into a hold register so the output is unaffected by memory.
  - After stall drops, sequential fetch resumes at the held pc.
- br_taken=1, which has priority over stall:
  - read issued at {br_target[31:2],2'b00}; pc<=that+4.
  - if_valid=1 next cycle with the target instruction.
  - The instruction on the outputs during the br_taken cycle is the pipeline's to squash.
- halt_req=1 (priority: halt_req > br_taken > stall): -> HALT; no read that cycle; if_valid<=0 next cycle.

HALT:
- All strobes low; if_valid=0; pc frozen.
- Exits only via rst.

mem_en is never high in IDLE or HALT.

Optional Feature:
Macro FETCH_COUNT_EN.
- Defined: fetch_count increments by 1 in every cycle where if_valid=1 and stall=0, so each instruction is counted once. Wraps at 2^32.
- Undefined: no counter logic; fetch_count tied to 0.

Test Plan:
- Reset mid-LOAD after 3 words -> all outputs at reset values, state_o=0. load_start, then 3 words with the third ld_last=1 -> writes at addr 0,1,2; RUN fetches pc 0,4,8 with matching if_instr.
- run_start with preloaded words 0x2001000A, 0x201E0014 -> if_pc 0 then 4, if_valid rises 1 cycle after the first mem_en.
- stall high 3 cycles while if_pc=4 -> if_pc/if_instr constant, mem_en=0, fetch resumes at pc 8; with FETCH_COUNT_EN, fetch_count counts pc 4 once.
- br_taken with br_target=0x0000000E and stall=1 in the same cycle -> mem_addr=3; next cycle if_pc=0x0C.
- Fetch reaches pc=4*DEPTH -> mem_en=0, if_instr=0, if_valid=1. Load DEPTH+1 words -> ld_overflow=1, exactly DEPTH writes.
- halt_req with br_taken in the same cycle -> HALT, no read, if_valid=0 thereafter; rst returns to IDLE.
